// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// the default operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 32'd8;

endpackage

// File: rtl/full_adder_behavioral.sv
// Single-bit full adder cell, time-shared by the serial adder controller.
module full_adder_behavioral (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds one bit pair per clock, LSB first, through
// a single full adder cell with the carry held in a register between cycles.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int unsigned CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fa_s, fa_cout;
    logic [WIDTH-1:0]   sum_next_s;

    full_adder_behavioral u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Next-state, datapath shifting and registered status decode
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_sh_d   = sum_sh_q;
        s_d        = s_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        // Written as shift-then-insert so WIDTH=1 needs no empty slice.
        sum_next_s = sum_sh_q >> 1;
        sum_next_s[WIDTH-1] = fa_s;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    carry_d  = Cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_sh_d = sum_next_s;
                carry_d  = fa_cout;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    s_d     = sum_next_s;
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: the driver queues expected sums and
// done times, a negedge monitor pops and compares whenever done is seen.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         cin_in;
    logic         busy, done;
    logic [W-1:0] s_out;
    logic         cout_out;

    int           n_cmp;
    int           n_err;
    int           cyc;
    logic [W:0]   exp_q[$];
    int           exp_cyc_q[$];
    logic [W:0]   held;
    logic         prev_done;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Cin   (cin_in),
        .busy  (busy),
        .done  (done),
        .S     (s_out),
        .Cout  (cout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: pops the scoreboard on every done, otherwise checks S/Cout hold
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                n_cmp++;
                if (prev_done) begin
                    n_err++;
                    $display("FAIL done_twice: got done high two cycles in a row at cyc %0d, required single pulse", cyc);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_done: got done at cyc %0d, required no pending operation", cyc);
                end else begin
                    logic [W:0] e;
                    int         c;
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    if ({cout_out, s_out} !== e) begin
                        n_err++;
                        $display("FAIL sum: got {Cout,S}=%h required %h", {cout_out, s_out}, e);
                    end
                    n_cmp++;
                    if (cyc !== c) begin
                        n_err++;
                        $display("FAIL done_time: got cyc %0d required cyc %0d", cyc, c);
                    end
                    held = e;
                end
            end else begin
                n_cmp++;
                if ({cout_out, s_out} !== held) begin
                    n_err++;
                    $display("FAIL hold: got {Cout,S}=%h required %h at cyc %0d", {cout_out, s_out}, held, cyc);
                end
            end
            prev_done = done;
        end
    end

    task automatic check1(input string name, input logic got, input logic req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %b required %b at cyc %0d", name, got, req, cyc);
        end
    endtask

    // mode 0: quiet inputs during the op; 1: random operands and start pulses;
    // 2: start held high with random operands (back-to-back).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input int mode);
        int k;
        @(negedge clk);
        a_in   = a;
        b_in   = b;
        cin_in = c;
        start  = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
        exp_cyc_q.push_back(k + W);
        start = (mode == 2);
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            check1("busy", busy, (i < W));
            if (mode != 0) begin
                a_in   = W'($urandom);
                b_in   = W'($urandom);
                cin_in = 1'($urandom);
                start  = (mode == 2) ? 1'b1 : 1'($urandom);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        held      = '0;
        prev_done = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        n_cmp++;
        if ({cout_out, s_out} !== 9'h000) begin
            n_err++;
            $display("FAIL rst_sum: got %h required 000", {cout_out, s_out});
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_op(8'h3C, 8'h42, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 0);
        run_op(8'h10, 8'h01, 1'b0, 1);
        run_op(8'h00, 8'h00, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0);

        // Abort in the middle of RUN: no done, outputs cleared at once.
        @(negedge clk);
        a_in   = 8'h77;
        b_in   = 8'h66;
        cin_in = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        n_cmp++;
        if ({cout_out, s_out} !== 9'h000) begin
            n_err++;
            $display("FAIL abort_sum: got %h required 000", {cout_out, s_out});
        end
        held = '0;
        @(posedge clk);
        #1;
        check1("rst_wins_busy", busy, 1'b0);
        start = 1'b0;
        #1;
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b1, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 2);
        end

        for (int i = 0; i < 500; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending results required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
